// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: constants and types shared by the timing controller and the
// instruction decoder (instdecode).
//   IntOpcode : opcode forced into the instruction register on interrupt or
//               reset entry (BRK).
//   CycW      : width of the per-instruction cycle counter.
//   Op*       : opcode values the decoder and the controller agree on.
//   step_e    : cycle-counter action selected by the decoder's step requests.
package cpu6502_pkg;

  localparam logic [7:0]  IntOpcode = 8'h00;
  localparam int unsigned CycW      = 3;

  localparam logic [7:0] OpBrk    = 8'h00;
  localparam logic [7:0] OpNop    = 8'hea;
  localparam logic [7:0] OpLdaImm = 8'ha9;
  localparam logic [7:0] OpJmpAbs = 8'h4c;

  typedef enum logic [2:0] {
    StepHold,
    StepInc,
    StepSkip,
    StepRet,
    StepTrap
  } step_e;

  // Decoder step requests in priority order: return > skip > increment.
  function automatic step_e step_sel(input logic rcyc, input logic scyc, input logic icyc);
    step_e s;
    s = StepHold;
    if (rcyc) begin
      s = StepRet;
    end else if (scyc) begin
      s = StepSkip;
    end else if (icyc) begin
      s = StepInc;
    end
    return s;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector with a registered previous sample.
//   clk  : clock, rising edge
//   clr  : synchronous active-low clear of the history register
//   en   : sample enable; history only advances when high
//   din  : level input
//   rise : combinational, high when din is high and the last sample was low
module edge_detect (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      prev_q <= 1'b0;
    end else if (en) begin
      prev_q <= din;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/timing_ctrl.sv
// timing_ctrl: instruction-cycle sequencer for a 6502-style core. Tracks the
// cycle within the current instruction, latches the opcode at cycle 0 and
// holds the reset / NMI / IRQ pending flags presented to the decoder.
//   clk      : clock, all state on rising edge
//   clr      : synchronous active-low reset, overrides rdy
//   rdy      : high advances, low stalls all state
//   dbin     : data bus, opcode at cycle 0
//   icyc     : step request, increment cycle
//   rcyc     : step request, return to cycle 0
//   scyc     : step request, skip one cycle (cycle + 2)
//   sinst    : decoder acknowledge of interrupt/reset entry
//   irq, nmi : interrupt lines, active-high
//   irqdis   : status-register I flag
//   inst     : instruction register
//   cycle    : cycle counter
//   rst_pend, nmi_pend, irq_pend : pending flags
//   fetch    : high while cycle == 0
//   ovf      : sticky, a step request wrapped the counter from its last value
//   illop    : sticky, an enabled edge carried no request at all
//              (present only with TIMING_CTRL_ILLOP_TRAP_EN defined)
// Build option: define TIMING_CTRL_ILLOP_TRAP_EN to trap request-less edges
// back to cycle 0; otherwise such edges simply hold the cycle.
module timing_ctrl
  import cpu6502_pkg::*;
#(
  parameter logic [7:0]  INT_OPCODE = IntOpcode,
  parameter int unsigned CYC_W      = CycW
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rdy,
  input  logic [7:0]       dbin,
  input  logic             icyc,
  input  logic             rcyc,
  input  logic             scyc,
  input  logic             sinst,
  input  logic             irq,
  input  logic             nmi,
  input  logic             irqdis,
  output logic [7:0]       inst,
  output logic [CYC_W-1:0] cycle,
  output logic             rst_pend,
  output logic             nmi_pend,
  output logic             irq_pend,
  output logic             fetch,
  output logic             ovf
`ifdef TIMING_CTRL_ILLOP_TRAP_EN
  ,
  output logic             illop
`endif
);

  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [7:0]       inst_q, inst_d;
  logic             rst_pend_q, rst_pend_d;
  logic             nmi_pend_q, nmi_pend_d;
  logic             irq_pend_q, irq_pend_d;
  logic             ovf_q, ovf_d;
  logic             nmi_rise;
  step_e            step;

  edge_detect u_nmi_edge (
    .clk  (clk),
    .clr  (clr),
    .en   (rdy),
    .din  (nmi),
    .rise (nmi_rise)
  );

  assign fetch = (cycle_q == '0);

  always_comb begin
    step = step_sel(rcyc, scyc, icyc);
`ifdef TIMING_CTRL_ILLOP_TRAP_EN
    // sinst alone is a legal (holding) edge; only a fully idle edge traps.
    if (step == StepHold && !sinst) begin
      step = StepTrap;
    end
`endif
  end

  always_comb begin
    cycle_d = cycle_q;
    unique case (step)
      StepHold: cycle_d = cycle_q;
      StepInc:  cycle_d = cycle_q + CYC_W'(1);
      StepSkip: cycle_d = cycle_q + CYC_W'(2);
      StepRet:  cycle_d = '0;
      StepTrap: cycle_d = '0;
      default:  cycle_d = cycle_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if ((step == StepInc || step == StepSkip) && cycle_q == {CYC_W{1'b1}}) begin
      ovf_d = 1'b1;
    end
  end

  // Opcode loads only on the cycle-0 increment; the rcyc edge keeps the old
  // opcode visible during the overlap cycle.
  always_comb begin
    inst_d = inst_q;
    if (fetch && icyc) begin
      inst_d = (rst_pend_q | nmi_pend_q | irq_pend_q) ? INT_OPCODE : dbin;
    end
  end

  // sinst retires only the highest-priority latched request; a fresh NMI edge
  // on the same cycle wins over the clear.
  always_comb begin
    rst_pend_d = rst_pend_q & ~sinst;
    nmi_pend_d = nmi_rise | (nmi_pend_q & ~(sinst & ~rst_pend_q));
    irq_pend_d = irq & ~irqdis;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cycle_q    <= '0;
      inst_q     <= INT_OPCODE;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      irq_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (rdy) begin
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      irq_pend_q <= irq_pend_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef TIMING_CTRL_ILLOP_TRAP_EN
  logic illop_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      illop_q <= 1'b0;
    end else if (rdy && step == StepTrap) begin
      illop_q <= 1'b1;
    end
  end

  assign illop = illop_q;
`endif

  assign cycle    = cycle_q;
  assign inst     = inst_q;
  assign rst_pend = rst_pend_q;
  assign nmi_pend = nmi_pend_q;
  assign irq_pend = irq_pend_q;
  assign ovf      = ovf_q;

endmodule
